// File: rtl/dht11_disp_fmt.sv
// dht11_disp_fmt: formats a DHT11 frame for the LCD character renderer.
//
// This block checks the 40-bit frame checksum. It converts the humidity and
// temperature integer bytes to BCD with two double-dabble lanes that run in
// lockstep. It keeps one committed temperature set and one committed humidity
// set, and alternates between the two sets on a free-running timer.
//
// Ports
//   lcd_pclk     in   pixel clock; every register is in this domain
//   sys_rst_n    in   asynchronous reset, active low
//   frame_valid  in   single-cycle strobe that qualifies frame
//   frame[39:0]  in   {hum_int, hum_dec, tmp_int, tmp_dec, checksum}
//   data[19:0]   out  BCD {hundreds, tens, units, tenths, hundredths}
//   sign         out  1 = negative value
//   flag_mux     out  0 = temperature view, 1 = humidity view
//   frame_ok     out  pulse for the cycle in which a frame is committed
//   crc_err      out  pulse for the cycle in which a frame is dropped on a bad checksum
//
// Optional build macro DHT11_STALE_DASH_EN: when no frame has been committed
// for STALE_CYCLES cycles, the display shows all dashes (20'hAAAAA).

module dht11_disp_fmt #(
  parameter logic [31:0] TOGGLE_CYCLES = 32'd99_999_999
`ifdef DHT11_STALE_DASH_EN
  , parameter logic [31:0] STALE_CYCLES = 32'd299_999_999
`endif
) (
  input  logic        lcd_pclk,
  input  logic        sys_rst_n,
  input  logic        frame_valid,
  input  logic [39:0] frame,
  output logic [19:0] data,
  output logic        sign,
  output logic        flag_mux,
  output logic        frame_ok,
  output logic        crc_err
);

  localparam int NUM_LANES = 2;  // lane 0 = temperature, lane 1 = humidity

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_CONV   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]  state;
  logic [39:0] hold;
  logic [39:0] pend_frame;
  logic        pend;
  logic [2:0]  it_cnt;
  logic [31:0] tmr;

  // Committed sets
  logic [19:0] set_t;
  logic        set_t_neg;
  logic [19:0] set_h;

  // ---------------------------------------------------------------- checksum
  logic [7:0] sum;
  logic       crc_ok;
  assign sum    = hold[39:32] + hold[31:24] + hold[23:16] + hold[15:8];
  assign crc_ok = (sum == hold[7:0]);

  assign frame_ok = (state == S_COMMIT);
  assign crc_err  = (state == S_CHECK) && !crc_ok;

  // ------------------------------------------------------- double-dabble lanes
  logic                               dd_load, dd_step;
  logic [NUM_LANES-1:0][7:0]          dd_in;
  logic [NUM_LANES-1:0][11:0]         dd_bcd;

  assign dd_load  = (state == S_CHECK) && crc_ok;
  assign dd_step  = (state == S_CONV);
  assign dd_in[0] = hold[23:16];
  assign dd_in[1] = hold[39:32];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    // {bcd[11:0], bin[7:0]}. The binary byte shifts out of the top of the
    // register into the BCD nibbles, MSB first.
    logic [19:0] sr;
    logic [19:0] adj;

    always_comb begin
      adj = sr;
      for (int n = 0; n < 3; n++) begin
        if (sr[8+4*n +: 4] >= 4'd5) adj[8+4*n +: 4] = sr[8+4*n +: 4] + 4'd3;
      end
    end

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n)   sr <= '0;
      else if (dd_load) sr <= {12'h000, dd_in[g]};
      else if (dd_step) sr <= {adj[18:0], 1'b0};
    end

    assign dd_bcd[g] = sr[19:8];
  end

  // ------------------------------------------------------------------ commit
  function automatic logic [3:0] clamp9(input logic [6:0] v);
    return (v > 7'd9) ? 4'd9 : v[3:0];
  endfunction

  logic [19:0] new_t, new_h;
  logic        new_t_neg;
  assign new_t     = {dd_bcd[0], clamp9(hold[14:8]), 4'h0};
  assign new_t_neg = hold[15];
  assign new_h     = {dd_bcd[1], clamp9(hold[30:24]), 4'h0};

  // The next-cycle view is built from the post-commit sets and the post-wrap
  // flag. This lets a commit and a toggle wrap in the same cycle land
  // together, so data, sign and flag_mux never show a mixed set.
  logic        wrap, flag_nxt, t_neg_nxt, sign_nxt;
  logic [19:0] t_nxt, h_nxt, data_nxt;

  assign wrap      = (tmr == TOGGLE_CYCLES - 32'd1);
  assign flag_nxt  = flag_mux ^ wrap;
  assign t_nxt     = frame_ok ? new_t     : set_t;
  assign t_neg_nxt = frame_ok ? new_t_neg : set_t_neg;
  assign h_nxt     = frame_ok ? new_h     : set_h;

`ifdef DHT11_STALE_DASH_EN
  logic [31:0] stale_cnt, stale_nxt;
  assign stale_nxt = frame_ok ? 32'd0 :
                     (stale_cnt == STALE_CYCLES) ? STALE_CYCLES : stale_cnt + 32'd1;

  always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) stale_cnt <= '0;
    else            stale_cnt <= stale_nxt;
  end

  always_comb begin
    data_nxt = flag_nxt ? h_nxt : t_nxt;
    sign_nxt = flag_nxt ? 1'b0  : t_neg_nxt;
    if (stale_nxt == STALE_CYCLES) begin
      data_nxt = 20'hAAAAA;
      sign_nxt = 1'b0;
    end
  end
`else
  always_comb begin
    data_nxt = flag_nxt ? h_nxt : t_nxt;
    sign_nxt = flag_nxt ? 1'b0  : t_neg_nxt;
  end
`endif

  always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmr       <= '0;
      flag_mux  <= 1'b0;
      data      <= '0;
      sign      <= 1'b0;
      set_t     <= '0;
      set_t_neg <= 1'b0;
      set_h     <= '0;
    end else begin
      tmr       <= wrap ? 32'd0 : tmr + 32'd1;
      flag_mux  <= flag_nxt;
      data      <= data_nxt;
      sign      <= sign_nxt;
      set_t     <= t_nxt;
      set_t_neg <= t_neg_nxt;
      set_h     <= h_nxt;
    end
  end

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      hold       <= '0;
      pend_frame <= '0;
      pend       <= 1'b0;
      it_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend) begin
            // The pending slot is served first. A frame arriving in the same
            // cycle takes over the slot, so it is not lost.
            hold  <= pend_frame;
            state <= S_CHECK;
            if (frame_valid) pend_frame <= frame;
            else             pend       <= 1'b0;
          end else if (frame_valid) begin
            hold  <= frame;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          it_cnt <= '0;
          state  <= crc_ok ? S_CONV : S_IDLE;
        end
        S_CONV: begin
          it_cnt <= it_cnt + 3'd1;
          if (it_cnt == 3'd7) state <= S_COMMIT;
        end
        default: state <= S_IDLE;  // S_COMMIT
      endcase

      // While busy, the newest arrival wins the one-deep slot.
      if (state != S_IDLE && frame_valid) begin
        pend       <= 1'b1;
        pend_frame <= frame;
      end
    end
  end

endmodule
